// File: rtl/ex_stage.sv
// Execute stage of the RV32IM pipeline: operand forwarding, ALU, single-cycle
// multiply, iterative restoring divider and branch resolution into EX/MEM.
module ex_stage #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned DIV_CYCLES = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic [XLEN-1:0] pc_in,
   input  logic [XLEN-1:0] rs1_data_in,
   input  logic [XLEN-1:0] rs2_data_in,
   input  logic [XLEN-1:0] imm_in,
   input  logic [4:0]      rs1_in,
   input  logic [4:0]      rs2_in,
   input  logic [4:0]      rd_in,
   input  logic [1:0]      alu_op_in,
   input  logic [2:0]      funct3_in,
   input  logic [6:0]      funct7_in,
   input  logic            alu_src_in,
   input  logic            branch_in,
   input  logic            mem_read_in,
   input  logic            mem_write_in,
   input  logic            reg_write_in,
   input  logic            mem_to_reg_in,
   input  logic [4:0]      exm_rd,
   input  logic            exm_reg_write,
   input  logic [XLEN-1:0] exm_result,
   input  logic [4:0]      mwb_rd,
   input  logic            mwb_reg_write,
   input  logic [XLEN-1:0] mwb_data,
   output logic            stall,
   output logic [XLEN-1:0] alu_result_out,
   output logic [XLEN-1:0] store_data_out,
   output logic [4:0]      rd_out,
   output logic            mem_read_out,
   output logic            mem_write_out,
   output logic            reg_write_out,
   output logic            mem_to_reg_out,
   output logic            branch_taken_out,
   output logic [XLEN-1:0] branch_target_out
);
   localparam int unsigned CW = $clog2(DIV_CYCLES);
   localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

   div_state_t      state;
   logic [CW-1:0]   count;
   logic [XLEN-1:0] dvd_q, rem_r, dsr;
   logic            neg_q, neg_r, hold_rem, hold_rw, hold_m2r;
   logic [4:0]      hold_rd;

   logic [XLEN-1:0]   op_a, fwd_b, op_b, sum, diff, sra_res, alu_res;
   logic [2*XLEN-1:0] mul_a, mul_b, prod;
   logic [4:0]        shamt;
   logic              is_m, is_div, div_signed, div_zero, div_ovf, div_start, cond;
   logic [XLEN:0]     rem_shift, rem_sub;
   logic [XLEN-1:0]   a_mag, b_mag, quo_fin, rem_fin;

   // Operand forwarding: EX/MEM has priority over MEM/WB; x0 is never forwarded
   always_comb begin
      if (exm_reg_write && exm_rd != 5'd0 && exm_rd == rs1_in)      op_a = exm_result;
      else if (mwb_reg_write && mwb_rd != 5'd0 && mwb_rd == rs1_in) op_a = mwb_data;
      else                                                          op_a = rs1_data_in;
      if (exm_reg_write && exm_rd != 5'd0 && exm_rd == rs2_in)      fwd_b = exm_result;
      else if (mwb_reg_write && mwb_rd != 5'd0 && mwb_rd == rs2_in) fwd_b = mwb_data;
      else                                                          fwd_b = rs2_data_in;
      op_b = alu_src_in ? imm_in : fwd_b;
   end

   always_comb begin
      sum        = op_a + op_b;
      diff       = op_a - op_b;
      shamt      = op_b[4:0];
      sra_res    = $signed(op_a) >>> shamt;
      is_m       = alu_op_in == 2'b10 && funct7_in == 7'b0000001 && !alu_src_in;
      is_div     = is_m && funct3_in[2];
      div_signed = !funct3_in[0];
      div_zero   = op_b == '0;
      div_ovf    = div_signed && op_a == INT_MIN && op_b == '1;
      div_start  = is_div && !div_zero && !div_ovf && !flush && state == IDLE;
      // MULH/MULHSU treat rs1 as signed; only MULH treats rs2 as signed
      mul_a = (funct3_in[1:0] != 2'b11) ? {{XLEN{op_a[XLEN-1]}}, op_a} : {{XLEN{1'b0}}, op_a};
      mul_b = (funct3_in[1:0] == 2'b01) ? {{XLEN{op_b[XLEN-1]}}, op_b} : {{XLEN{1'b0}}, op_b};
      prod  = mul_a * mul_b;
      cond    = 1'b0;
      alu_res = sum;
      case (alu_op_in)
         2'b01: begin
            alu_res = diff;
            case (funct3_in)
               3'b000:  cond = op_a == op_b;
               3'b001:  cond = op_a != op_b;
               3'b100:  cond = $signed(op_a) < $signed(op_b);
               3'b101:  cond = $signed(op_a) >= $signed(op_b);
               3'b110:  cond = op_a < op_b;
               3'b111:  cond = op_a >= op_b;
               default: cond = 1'b0;
            endcase
         end
         2'b10: begin
            if (is_m) begin
               if (!funct3_in[2])
                  alu_res = (funct3_in[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
               else if (div_zero)
                  alu_res = funct3_in[1] ? op_a : '1;
               else if (div_ovf)
                  alu_res = funct3_in[1] ? '0 : INT_MIN;
               else
                  alu_res = '0;
            end else begin
               case (funct3_in)
                  3'b000:  alu_res = (funct7_in[5] && !alu_src_in) ? diff : sum;
                  3'b001:  alu_res = op_a << shamt;
                  3'b010:  alu_res = XLEN'($signed(op_a) < $signed(op_b));
                  3'b011:  alu_res = XLEN'(op_a < op_b);
                  3'b100:  alu_res = op_a ^ op_b;
                  3'b101:  alu_res = funct7_in[5] ? sra_res : op_a >> shamt;
                  3'b110:  alu_res = op_a | op_b;
                  default: alu_res = op_a & op_b;
               endcase
            end
         end
         default: alu_res = sum;
      endcase
   end

   // Restoring divider datapath on magnitudes, sign fixed up at the end
   always_comb begin
      a_mag     = (div_signed && op_a[XLEN-1]) ? -op_a : op_a;
      b_mag     = (div_signed && op_b[XLEN-1]) ? -op_b : op_b;
      rem_shift = {rem_r, dvd_q[XLEN-1]};
      rem_sub   = rem_shift - {1'b0, dsr};
      quo_fin   = neg_q ? -dvd_q : dvd_q;
      rem_fin   = neg_r ? -rem_r : rem_r;
   end

   assign stall = rst_n && !flush && (div_start || state == BUSY);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         count <= '0;
         dvd_q <= '0;
         rem_r <= '0;
         dsr   <= '0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
         hold_rem <= 1'b0;
         hold_rw  <= 1'b0;
         hold_m2r <= 1'b0;
         hold_rd  <= '0;
         alu_result_out    <= '0;
         store_data_out    <= '0;
         rd_out            <= '0;
         mem_read_out      <= 1'b0;
         mem_write_out     <= 1'b0;
         reg_write_out     <= 1'b0;
         mem_to_reg_out    <= 1'b0;
         branch_taken_out  <= 1'b0;
         branch_target_out <= '0;
      end else begin
         // Bubble unless one of the branches below writes a real result
         alu_result_out    <= '0;
         store_data_out    <= '0;
         rd_out            <= '0;
         mem_read_out      <= 1'b0;
         mem_write_out     <= 1'b0;
         reg_write_out     <= 1'b0;
         mem_to_reg_out    <= 1'b0;
         branch_taken_out  <= 1'b0;
         branch_target_out <= '0;
         case (state)
            IDLE: begin
               if (div_start) begin
                  state    <= BUSY;
                  count    <= '0;
                  dvd_q    <= a_mag;
                  rem_r    <= '0;
                  dsr      <= b_mag;
                  neg_q    <= div_signed && (op_a[XLEN-1] ^ op_b[XLEN-1]);
                  neg_r    <= div_signed && op_a[XLEN-1];
                  hold_rem <= funct3_in[1];
                  hold_rd  <= rd_in;
                  hold_rw  <= reg_write_in;
                  hold_m2r <= mem_to_reg_in;
               end else if (!flush) begin
                  alu_result_out    <= alu_res;
                  store_data_out    <= fwd_b;
                  rd_out            <= rd_in;
                  mem_read_out      <= mem_read_in;
                  mem_write_out     <= mem_write_in;
                  reg_write_out     <= reg_write_in;
                  mem_to_reg_out    <= mem_to_reg_in;
                  branch_taken_out  <= branch_in && cond;
                  branch_target_out <= pc_in + imm_in;
               end
            end
            BUSY: begin
               if (flush) begin
                  state <= IDLE;
               end else begin
                  rem_r <= rem_sub[XLEN] ? rem_shift[XLEN-1:0] : rem_sub[XLEN-1:0];
                  dvd_q <= {dvd_q[XLEN-2:0], !rem_sub[XLEN]};
                  count <= count + CW'(1);
                  if (count == CW'(DIV_CYCLES - 1)) state <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
               if (!flush) begin
                  alu_result_out <= hold_rem ? rem_fin : quo_fin;
                  rd_out         <= hold_rd;
                  reg_write_out  <= hold_rw;
                  mem_to_reg_out <= hold_m2r;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: expectations are queued when an instruction is
// driven and popped when its EX/MEM result is due.
module tb_ex_stage;
   logic        clk = 1'b0;
   logic        rst_n, flush;
   logic [31:0] pc_in, rs1_data_in, rs2_data_in, imm_in;
   logic [4:0]  rs1_in, rs2_in, rd_in;
   logic [1:0]  alu_op_in;
   logic [2:0]  funct3_in;
   logic [6:0]  funct7_in;
   logic        alu_src_in, branch_in, mem_read_in, mem_write_in, reg_write_in, mem_to_reg_in;
   logic [4:0]  exm_rd, mwb_rd;
   logic        exm_reg_write, mwb_reg_write;
   logic [31:0] exm_result, mwb_data;
   logic        stall;
   logic [31:0] alu_result_out, store_data_out, branch_target_out;
   logic [4:0]  rd_out;
   logic        mem_read_out, mem_write_out, reg_write_out, mem_to_reg_out, branch_taken_out;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  rd;
      logic        rw;
      logic        tk;
      logic [31:0] tgt;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   passes = 0;

   ex_stage dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .pc_in(pc_in), .rs1_data_in(rs1_data_in), .rs2_data_in(rs2_data_in), .imm_in(imm_in),
      .rs1_in(rs1_in), .rs2_in(rs2_in), .rd_in(rd_in),
      .alu_op_in(alu_op_in), .funct3_in(funct3_in), .funct7_in(funct7_in),
      .alu_src_in(alu_src_in), .branch_in(branch_in), .mem_read_in(mem_read_in),
      .mem_write_in(mem_write_in), .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in),
      .exm_rd(exm_rd), .exm_reg_write(exm_reg_write), .exm_result(exm_result),
      .mwb_rd(mwb_rd), .mwb_reg_write(mwb_reg_write), .mwb_data(mwb_data),
      .stall(stall), .alu_result_out(alu_result_out), .store_data_out(store_data_out),
      .rd_out(rd_out), .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
      .reg_write_out(reg_write_out), .mem_to_reg_out(mem_to_reg_out),
      .branch_taken_out(branch_taken_out), .branch_target_out(branch_target_out)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic drive(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                        input logic src, input logic [31:0] a, input logic [31:0] b);
      alu_op_in = op; funct7_in = f7; funct3_in = f3; alu_src_in = src;
      rs1_in = 5'd1; rs2_in = 5'd2; rd_in = 5'd3; pc_in = 32'h100;
      rs1_data_in = a;
      rs2_data_in = src ? 32'hDEAD_BEEF : b;
      imm_in      = src ? b : 32'h0;
      reg_write_in = (op != 2'b01); branch_in = (op == 2'b01);
      mem_read_in = 1'b0; mem_write_in = 1'b0; mem_to_reg_in = 1'b0;
      exm_rd = '0; exm_reg_write = 1'b0; exm_result = '0;
      mwb_rd = '0; mwb_reg_write = 1'b0; mwb_data = '0;
      flush = 1'b0;
   endtask

   task automatic nop();
      drive(2'b00, 7'd0, 3'd0, 1'b0, 32'd0, 32'd0);
      reg_write_in = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(2'b10, 7'd1, 3'd4, 1'b0, 32'd100, 32'd3);
      repeat (2) @(negedge clk);
      checks++; if (alu_result_out !== 32'h0) $display("FAIL reset_result: got %h required 0", alu_result_out); else passes++;
      checks++; if (reg_write_out !== 1'b0) $display("FAIL reset_reg_write: got %b required 0", reg_write_out); else passes++;
      checks++; if (branch_target_out !== 32'h0) $display("FAIL reset_target: got %h required 0", branch_target_out); else passes++;
      checks++; if (stall !== 1'b0) $display("FAIL reset_stall: got %b required 0", stall); else passes++;
      nop();
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_forwarding();
      int exr[4] = '{1, 0, 4, 4};
      int mwr[4] = '{1, 0, 1, 6};
      int rs1[4] = '{1, 0, 1, 1};
      logic [31:0] rd1[4] = '{32'd100, 32'd0, 32'd100, 32'd100};
      logic [31:0] expv[4] = '{32'd12, 32'd7, 32'd16, 32'd107};
      exp_t e;
      for (int i = 0; i < 4; i++) begin
         drive(2'b10, 7'd0, 3'd0, 1'b0, rd1[i], 32'd7);
         rs1_in = 5'(rs1[i]);
         exm_rd = 5'(exr[i]); exm_reg_write = 1'b1; exm_result = 32'd5;
         mwb_rd = 5'(mwr[i]); mwb_reg_write = 1'b1; mwb_data = 32'd9;
         sb.push_back('{res: expv[i], rd: 5'd3, rw: 1'b1, tk: 1'b0, tgt: 32'h100});
         @(negedge clk);
         e = sb.pop_front();
         checks++; if (alu_result_out !== e.res) $display("FAIL fwd_%0d: result %h required %h", i, alu_result_out, e.res); else passes++;
      end
      // store: address = rs1+imm, store data forwarded from MEM/WB on rs2
      drive(2'b00, 7'd0, 3'd0, 1'b1, 32'h40, 32'h8);
      reg_write_in = 1'b0; mem_write_in = 1'b1;
      mwb_rd = 5'd2; mwb_reg_write = 1'b1; mwb_data = 32'd9;
      @(negedge clk);
      checks++; if (alu_result_out !== 32'h48) $display("FAIL store_addr: got %h required 48", alu_result_out); else passes++;
      checks++; if (store_data_out !== 32'd9 || mem_write_out !== 1'b1) $display("FAIL store_data: got %h/%b required 9/1", store_data_out, mem_write_out); else passes++;
   endtask

   task automatic test_alu();
      logic [6:0]  f7[11] = '{7'h20, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h20, 7'h00, 7'h00, 7'h01};
      logic [2:0]  f3[11] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd7, 3'd0};
      logic        src[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      logic [31:0] av[11] = '{32'd10, 32'd10, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hF0F0,
                              32'h80000000, 32'h80000000, 32'hF0, 32'hF0, 32'd2};
      logic [31:0] bv[11] = '{32'd3, 32'd3, 32'h23, 32'd1, 32'd1, 32'hFF00, 32'd4, 32'd4,
                              32'h0F, 32'h3C, 32'd3};
      logic [31:0] xv[11] = '{32'd7, 32'd13, 32'd8, 32'd1, 32'd0, 32'h0FF0, 32'h08000000,
                              32'hF8000000, 32'hFF, 32'h30, 32'd5};
      exp_t e;
      for (int i = 0; i < 11; i++) begin
         drive(2'b10, f7[i], f3[i], src[i], av[i], bv[i]);
         sb.push_back('{res: xv[i], rd: 5'd3, rw: 1'b1, tk: 1'b0, tgt: 32'h100});
         @(negedge clk);
         e = sb.pop_front();
         checks++; if (alu_result_out !== e.res || reg_write_out !== e.rw) $display("FAIL alu_%0d: result %h rw %b required %h rw %b", i, alu_result_out, reg_write_out, e.res, e.rw); else passes++;
      end
   endtask

   task automatic test_mul();
      logic [2:0]  f3[4] = '{3'd1, 3'd3, 3'd0, 3'd2};
      logic [31:0] av[4] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
      logic [31:0] bv[4] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2};
      logic [31:0] xv[4] = '{32'h40000000, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFF};
      exp_t e;
      for (int i = 0; i < 4; i++) begin
         drive(2'b10, 7'd1, f3[i], 1'b0, av[i], bv[i]);
         sb.push_back('{res: xv[i], rd: 5'd3, rw: 1'b1, tk: 1'b0, tgt: 32'h100});
         #1;
         checks++; if (stall !== 1'b0) $display("FAIL mul_stall_%0d: got %b required 0", i, stall); else passes++;
         @(negedge clk);
         e = sb.pop_front();
         checks++; if (alu_result_out !== e.res) $display("FAIL mul_%0d: result %h required %h", i, alu_result_out, e.res); else passes++;
      end
   endtask

   task automatic test_branch();
      logic [2:0]  f3[8] = '{3'd4, 3'd6, 3'd0, 3'd1, 3'd5, 3'd7, 3'd2, 3'd0};
      logic [31:0] av[8] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5, 32'd5};
      logic [31:0] bv[8] = '{32'd1, 32'd1, 32'd5, 32'd5, 32'd1, 32'd1, 32'd5, 32'd5};
      logic        br[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      logic        tk[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [31:0] xv[8] = '{32'hFFFFFFFE, 32'hFFFFFFFE, 32'd0, 32'd0, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'd0, 32'd0};
      exp_t e;
      for (int i = 0; i < 8; i++) begin
         drive(2'b01, 7'd0, f3[i], 1'b0, av[i], bv[i]);
         imm_in = 32'h20; branch_in = br[i];
         sb.push_back('{res: xv[i], rd: 5'd3, rw: 1'b0, tk: tk[i], tgt: 32'h120});
         @(negedge clk);
         e = sb.pop_front();
         checks++; if (branch_taken_out !== e.tk) $display("FAIL br_taken_%0d: got %b required %b", i, branch_taken_out, e.tk); else passes++;
         checks++; if (branch_target_out !== e.tgt || alu_result_out !== e.res) $display("FAIL br_data_%0d: target %h result %h required %h %h", i, branch_target_out, alu_result_out, e.tgt, e.res); else passes++;
      end
   endtask

   task automatic test_div();
      logic [2:0]  f3[4] = '{3'd4, 3'd6, 3'd5, 3'd7};
      logic [31:0] av[4] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'd100};
      logic [31:0] bv[4] = '{32'd2, 32'd2, 32'd2, 32'd7};
      logic [31:0] xv[4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'd2};
      exp_t e;
      int n;
      for (int i = 0; i < 4; i++) begin
         drive(2'b10, 7'd1, f3[i], 1'b0, av[i], bv[i]);
         rd_in = 5'(10 + i);
         sb.push_back('{res: xv[i], rd: 5'(10 + i), rw: 1'b1, tk: 1'b0, tgt: 32'h0});
         n = 0;
         for (int k = 0; k < 100; k++) begin
            #1;
            if (!stall) break;
            n++;
            if (n == 5) begin
               checks++; if (reg_write_out !== 1'b0) $display("FAIL div_bubble_%0d: reg_write_out %b required 0", i, reg_write_out); else passes++;
            end
            @(negedge clk);
         end
         checks++; if (n != 33) $display("FAIL div_stall_len_%0d: got %0d required 33", i, n); else passes++;
         @(negedge clk);
         e = sb.pop_front();
         checks++; if (alu_result_out !== e.res || reg_write_out !== e.rw || rd_out !== e.rd) $display("FAIL div_%0d: result %h rw %b rd %0d required %h %b %0d", i, alu_result_out, reg_write_out, rd_out, e.res, e.rw, e.rd); else passes++;
      end
      nop();
   endtask

   task automatic test_div_special();
      logic [2:0]  f3[4] = '{3'd4, 3'd6, 3'd4, 3'd6};
      logic [31:0] av[4] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000};
      logic [31:0] bv[4] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
      logic [31:0] xv[4] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};
      exp_t e;
      for (int i = 0; i < 4; i++) begin
         drive(2'b10, 7'd1, f3[i], 1'b0, av[i], bv[i]);
         sb.push_back('{res: xv[i], rd: 5'd3, rw: 1'b1, tk: 1'b0, tgt: 32'h0});
         #1;
         checks++; if (stall !== 1'b0) $display("FAIL divsp_stall_%0d: got %b required 0", i, stall); else passes++;
         @(negedge clk);
         e = sb.pop_front();
         checks++; if (alu_result_out !== e.res || reg_write_out !== e.rw) $display("FAIL divsp_%0d: result %h rw %b required %h %b", i, alu_result_out, reg_write_out, e.res, e.rw); else passes++;
      end
      nop();
   endtask

   task automatic test_flush();
      exp_t e;
      drive(2'b10, 7'd1, 3'd4, 1'b0, 32'hFFFFFFF9, 32'd2);
      repeat (11) @(negedge clk);
      flush = 1'b1;
      #1;
      checks++; if (stall !== 1'b0) $display("FAIL flush_busy_stall: got %b required 0", stall); else passes++;
      @(negedge clk);
      checks++; if (reg_write_out !== 1'b0) $display("FAIL flush_busy_bubble: reg_write_out %b required 0", reg_write_out); else passes++;
      nop();
      #1;
      checks++; if (stall !== 1'b0) $display("FAIL flush_idle_stall: got %b required 0", stall); else passes++;
      @(negedge clk);
      // flush together with a divide issue: no divider start
      drive(2'b10, 7'd1, 3'd4, 1'b0, 32'd40, 32'd3);
      flush = 1'b1;
      #1;
      checks++; if (stall !== 1'b0) $display("FAIL flush_start_stall: got %b required 0", stall); else passes++;
      @(negedge clk);
      checks++; if (reg_write_out !== 1'b0) $display("FAIL flush_start_bubble: reg_write_out %b required 0", reg_write_out); else passes++;
      drive(2'b10, 7'd0, 3'd0, 1'b0, 32'd2, 32'd3);
      sb.push_back('{res: 32'd5, rd: 5'd3, rw: 1'b1, tk: 1'b0, tgt: 32'h100});
      #1;
      checks++; if (stall !== 1'b0) $display("FAIL flush_after_stall: got %b required 0", stall); else passes++;
      @(negedge clk);
      e = sb.pop_front();
      checks++; if (alu_result_out !== e.res || reg_write_out !== e.rw) $display("FAIL flush_after_add: result %h rw %b required %h %b", alu_result_out, reg_write_out, e.res, e.rw); else passes++;
      drive(2'b10, 7'd0, 3'd0, 1'b0, 32'd2, 32'd3);
      flush = 1'b1;
      @(negedge clk);
      checks++; if (reg_write_out !== 1'b0 || alu_result_out !== 32'h0) $display("FAIL flush_add_bubble: rw %b result %h required 0 0", reg_write_out, alu_result_out); else passes++;
      nop();
   endtask

   task automatic test_reset_mid_div();
      exp_t e;
      int writes;
      drive(2'b10, 7'd1, 3'd4, 1'b0, 32'd1000, 32'd7);
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      checks++; if (alu_result_out !== 32'h0 || reg_write_out !== 1'b0 || rd_out !== 5'd0) $display("FAIL rst_mid_outputs: result %h rw %b rd %0d required 0 0 0", alu_result_out, reg_write_out, rd_out); else passes++;
      checks++; if (stall !== 1'b0) $display("FAIL rst_mid_stall: got %b required 0", stall); else passes++;
      nop();
      rst_n = 1'b1;
      writes = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (reg_write_out !== 1'b0 || stall !== 1'b0) writes++;
      end
      checks++; if (writes != 0) $display("FAIL rst_mid_no_result: %0d active cycles required 0", writes); else passes++;
      drive(2'b10, 7'd0, 3'd0, 1'b0, 32'd20, 32'd22);
      sb.push_back('{res: 32'd42, rd: 5'd3, rw: 1'b1, tk: 1'b0, tgt: 32'h100});
      @(negedge clk);
      e = sb.pop_front();
      checks++; if (alu_result_out !== e.res || reg_write_out !== e.rw) $display("FAIL rst_mid_after: result %h rw %b required %h %b", alu_result_out, reg_write_out, e.res, e.rw); else passes++;
      nop();
   endtask

   initial begin
      test_reset();
      test_forwarding();
      test_alu();
      test_mul();
      test_branch();
      test_div();
      test_div_special();
      test_flush();
      test_reset_mid_div();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
